// File: rtl/prog_rom_pkg.sv
// Shared types and constants for the program ROM and its instruction decoder.
package prog_rom_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } burst_state_e;

  // Field slices of a stored word at the default 16-bit half width.
  localparam int ROM_HALF_WIDTH = 16;
  localparam int OPCODE_HI      = 2 * ROM_HALF_WIDTH - 1;
  localparam int OPCODE_LO      = ROM_HALF_WIDTH;
  localparam int OPERAND_HI     = ROM_HALF_WIDTH - 1;
  localparam int OPERAND_LO     = 0;

  // Decoder encodings that launch a data burst from this ROM.
  localparam logic [3:0] ROM_OP        = 4'h3;
  localparam logic [3:0] ROM_DATA_READ = 4'h1;

endpackage

// File: rtl/rom_mem_2r1w.sv
// Storage array with two registered read ports and one write port.
// A read and a write to the same address on the same edge return the old word.
module rom_mem_2r1w #(
  parameter int    WIDTH      = 32,
  parameter int    ADDR_WIDTH = 8,
  parameter int    DEPTH      = 2 ** ADDR_WIDTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read registers only update on their enable, so a held word is immune to later writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (rd_en_a) rd_data_a <= mem[rd_addr_a];
      if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    end
  end

endmodule

// File: rtl/prog_rom_stream.sv
// Program ROM front end: registered instruction fetch port plus a handshaked
// operand burst streamer, sharing a run-time loadable 2R1W array.
module prog_rom_stream
  import prog_rom_pkg::*;
#(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 8,
  parameter int    DEPTH      = 2 ** ADDR_WIDTH,
  parameter string INIT_FILE  = "program.mem"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_opcode,
  output logic [DATA_WIDTH-1:0]   fetch_operand,
  input  logic                    burst_start,
  input  logic [ADDR_WIDTH-1:0]   burst_addr,
  input  logic [ADDR_WIDTH-1:0]   burst_len,
  output logic                    burst_busy,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_last,
  input  logic                    load_en,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [2*DATA_WIDTH-1:0] load_data,
  output burst_state_e            burst_state
);

  localparam int WORD_WIDTH = 2 * DATA_WIDTH;

  burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, next_addr;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  rd_en_b;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [WORD_WIDTH-1:0] fetch_word, burst_word;
  logic                  unused_burst_opcode;

  rom_mem_2r1w #(
    .WIDTH     (WORD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_a  (fetch_req),
    .rd_addr_a(fetch_addr),
    .rd_data_a(fetch_word),
    .rd_en_b  (rd_en_b),
    .rd_addr_b(rd_addr_b),
    .rd_data_b(burst_word),
    .wr_en    (load_en),
    .wr_addr  (load_addr),
    .wr_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_valid <= 1'b0;
    else        fetch_valid <= fetch_req;
  end

  assign fetch_opcode  = fetch_word[WORD_WIDTH-1:DATA_WIDTH];
  assign fetch_operand = fetch_word[DATA_WIDTH-1:0];

  assign data_out            = burst_word[DATA_WIDTH-1:0];
  assign unused_burst_opcode = ^burst_word[WORD_WIDTH-1:DATA_WIDTH];

  assign next_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // Stream handshake: a word transfers on any rising edge where data_valid and
  // data_ready are both high; data_valid never drops and data_out never changes
  // until that transfer happens. The next word is read on the transfer edge,
  // so a consumer holding ready high sees one word per cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    rd_en_b   = 1'b0;
    rd_addr_b = addr_q;
    unique case (state_q)
      IDLE: begin
        if (burst_start && (burst_len != '0)) begin
          state_d   = STREAM;
          addr_d    = burst_addr;
          count_d   = burst_len;
          rd_en_b   = 1'b1;
          rd_addr_b = burst_addr;
        end
      end
      STREAM: begin
        if (data_ready) begin
          if (count_q == ADDR_WIDTH'(1)) begin
            state_d = IDLE;
          end else begin
            addr_d    = next_addr;
            count_d   = count_q - 1'b1;
            rd_en_b   = 1'b1;
            rd_addr_b = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_valid  = (state_q == STREAM);
  assign data_last   = data_valid && (count_q == ADDR_WIDTH'(1));
  assign burst_busy  = (state_q != IDLE);
  assign burst_state = state_q;

endmodule

// File: tb/tb_prog_rom_stream.sv
// Self-checking bench for prog_rom_stream: fetch table, directed burst corners,
// and randomized bursts with concurrent fetches against a memory-image model.
module tb_prog_rom_stream;
  import prog_rom_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_req;
  logic [AW-1:0]   fetch_addr;
  logic            fetch_valid;
  logic [DW-1:0]   fetch_opcode, fetch_operand;
  logic            burst_start;
  logic [AW-1:0]   burst_addr, burst_len;
  logic            burst_busy, data_valid, data_ready, data_last;
  logic [DW-1:0]   data_out;
  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [2*DW-1:0] load_data;
  burst_state_e    burst_state;

  prog_rom_stream #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .fetch_opcode (fetch_opcode),
    .fetch_operand(fetch_operand),
    .burst_start  (burst_start),
    .burst_addr   (burst_addr),
    .burst_len    (burst_len),
    .burst_busy   (burst_busy),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data_out     (data_out),
    .data_last    (data_last),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .burst_state  (burst_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model + scoreboard ----------------
  int              checks   = 0;
  int              failures = 0;
  logic [2*DW-1:0] model_mem [DEPTH];
  logic [DW-1:0]   exp_q[$];

  typedef struct {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] word;
  } fetch_vec_t;
  fetch_vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [2*DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_opcode", fetch_opcode, model_mem[a][2*DW-1:DW]);
    chk("fetch_operand", fetch_operand, model_mem[a][DW-1:0]);
  endtask

  // mode: 0 = ready held high, 1 = ready pattern 1,0,0,..., 2 = random ready
  task automatic run_burst(input logic [AW-1:0] a, input logic [AW-1:0] len,
                           input int mode, input bit rand_fetch);
    int            cyc = 0;
    logic          prev_fq;
    logic [AW-1:0] prev_fa;
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back(model_mem[(int'(a) + i) % DEPTH][DW-1:0]);
    burst_start = 1'b1; burst_addr = a; burst_len = len;
    tick();
    burst_start = 1'b0;
    chk("burst_busy_start", burst_busy, 1);
    while (exp_q.size() != 0 && cyc < 200) begin
      case (mode)
        0:       data_ready = 1'b1;
        1:       data_ready = (cyc % 3 == 0);
        default: data_ready = 1'(($urandom_range(0, 1)));
      endcase
      if (rand_fetch) begin
        fetch_req  = 1'($urandom_range(0, 1));
        fetch_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      chk("data_valid", data_valid, 1);
      chk("data_out", data_out, exp_q[0]);
      chk("data_last", data_last, (exp_q.size() == 1));
      if (data_ready) void'(exp_q.pop_front());
      prev_fq = fetch_req;
      prev_fa = fetch_addr;
      tick();
      cyc++;
      if (rand_fetch) begin
        chk("fetch_valid_conc", fetch_valid, prev_fq);
        if (prev_fq) begin
          chk("fetch_opcode_conc", fetch_opcode, model_mem[prev_fa][2*DW-1:DW]);
          chk("fetch_operand_conc", fetch_operand, model_mem[prev_fa][DW-1:0]);
        end
      end
    end
    if (exp_q.size() != 0) begin
      chk("burst_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
    data_ready = 1'b0;
    fetch_req  = 1'b0;
    if (mode == 0) chk("burst_cycles", cyc, int'(len));
    chk("burst_busy_end", burst_busy, 0);
    chk("data_valid_end", data_valid, 0);
    chk("data_last_end", data_last, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2*DW-1:0] old_w;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    burst_start = 1'b0; burst_addr = '0; burst_len = '0; data_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) tick();
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_opcode", fetch_opcode, 0);
    chk("rst_fetch_operand", fetch_operand, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_last", data_last, 0);
    chk("rst_burst_busy", burst_busy, 0);
    chk("rst_state", burst_state, IDLE);
    rst_n = 1'b1;
    tick();

    // Known instruction word.
    do_load(8'd5, 32'h3102_0040);
    fetch_req = 1'b1; fetch_addr = 8'd5;
    tick();
    fetch_req = 1'b0;
    chk("w5_valid", fetch_valid, 1);
    chk("w5_opcode", fetch_opcode, 16'h3102);
    chk("w5_operand", fetch_operand, 16'h0040);
    tick();
    chk("fetch_valid_pulse", fetch_valid, 0);
    chk("fetch_hold_opcode", fetch_opcode, 16'h3102);

    // Table-driven back-to-back fetches.
    vecs[0] = '{8'd1,   32'h0101_A001};
    vecs[1] = '{8'd2,   32'h0202_B002};
    vecs[2] = '{8'd3,   32'hFFFF_0000};
    vecs[3] = '{8'd100, 32'h0000_FFFF};
    vecs[4] = '{8'd128, 32'h8000_0001};
    vecs[5] = '{8'd200, 32'h1234_5678};
    vecs[6] = '{8'd254, 32'hCAFE_0254};
    vecs[7] = '{8'd255, 32'hBABE_0255};
    foreach (vecs[i]) do_load(vecs[i].addr, vecs[i].word);
    fetch_req = 1'b1;
    foreach (vecs[i]) begin
      fetch_addr = vecs[i].addr;
      tick();
      chk("tbl_valid", fetch_valid, 1);
      chk("tbl_opcode", fetch_opcode, vecs[i].word[OPCODE_HI:OPCODE_LO]);
      chk("tbl_operand", fetch_operand, vecs[i].word[OPERAND_HI:OPERAND_LO]);
    end
    fetch_req = 1'b0;
    tick();
    chk("tbl_valid_drop", fetch_valid, 0);
    chk("tbl_hold_operand", fetch_operand, 16'h0255);

    // Load and fetch of the same address on one edge returns the old word.
    do_load(8'd7, 32'h0BAD_F00D);
    load_en = 1'b1; load_addr = 8'd7; load_data = 32'hDEAD_BEEF;
    fetch_req = 1'b1; fetch_addr = 8'd7;
    tick();
    load_en = 1'b0; fetch_req = 1'b0;
    model_mem[7] = 32'hDEAD_BEEF;
    chk("rw_old_opcode", fetch_opcode, 16'h0BAD);
    chk("rw_old_operand", fetch_operand, 16'hF00D);
    fetch_req = 1'b1; fetch_addr = 8'd7;
    tick();
    fetch_req = 1'b0;
    chk("rw_new_opcode", fetch_opcode, 16'hDEAD);
    chk("rw_new_operand", fetch_operand, 16'hBEEF);

    // Directed bursts.
    for (int a = 10; a < 14; a++) do_load(AW'(a), {16'hA000 + 16'(a), 16'h5000 + 16'(a)});
    do_load(8'd0, 32'h1111_0F00);
    do_load(8'd1, 32'h2222_0F01);
    run_burst(8'd10, 8'd4, 0, 1'b0);
    run_burst(8'd10, 8'd4, 1, 1'b0);
    run_burst(8'd254, 8'd4, 0, 1'b0);
    run_burst(8'd13, 8'd1, 0, 1'b0);

    burst_start = 1'b1; burst_addr = 8'd3; burst_len = 8'd0;
    tick();
    burst_start = 1'b0;
    chk("len0_busy", burst_busy, 0);
    chk("len0_valid", data_valid, 0);
    chk("len0_state", burst_state, IDLE);

    // Held word survives a load to its address; burst_start ignored while busy.
    do_load(8'd40, 32'h0000_4040);
    do_load(8'd41, 32'h0000_4141);
    burst_start = 1'b1; burst_addr = 8'd40; burst_len = 8'd2;
    tick();
    data_ready = 1'b0;
    burst_addr = 8'd99; burst_len = 8'd5;
    load_en = 1'b1; load_addr = 8'd40; load_data = 32'h7777_9999;
    tick();
    burst_start = 1'b0; load_en = 1'b0;
    model_mem[40] = 32'h7777_9999;
    chk("hold_after_load", data_out, 16'h4040);
    chk("hold_valid", data_valid, 1);
    data_ready = 1'b1;
    tick();
    chk("hold_second_word", data_out, 16'h4141);
    chk("hold_second_last", data_last, 1);
    tick();
    data_ready = 1'b0;
    chk("hold_busy_end", burst_busy, 0);
    do_fetch(8'd40);

    // Asynchronous reset during the second word of a six-word burst.
    for (int a = 30; a < 36; a++) do_load(AW'(a), 32'($urandom));
    burst_start = 1'b1; burst_addr = 8'd30; burst_len = 8'd6; data_ready = 1'b1;
    tick();
    burst_start = 1'b0;
    chk("rstb_word0", data_out, model_mem[30][DW-1:0]);
    tick();
    chk("rstb_word1", data_out, model_mem[31][DW-1:0]);
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_valid", data_valid, 0);
    chk("rstb_data_out", data_out, 0);
    chk("rstb_last", data_last, 0);
    chk("rstb_busy", burst_busy, 0);
    chk("rstb_state", burst_state, IDLE);
    chk("rstb_fetch_opcode", fetch_opcode, 0);
    data_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_burst(8'd30, 8'd6, 0, 1'b0);

    // Randomized bursts with concurrent fetches.
    for (int i = 0; i < 64; i++)
      do_load(AW'($urandom_range(0, DEPTH - 1)), 32'($urandom));
    for (int i = 0; i < 20; i++)
      run_burst(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(1, 8)), 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
